// File: rtl/boot_image_loader_if.sv
// Byte-stream input and RAM write-port bundle for the boot image loader.
// master = loader side, slave = stream source / RAM / status observer side.
interface boot_image_loader_if #(
  parameter int RAM_ADDR_WIDTH = 8
);
  logic                      in_valid;
  logic [7:0]                in_data;
  logic                      in_ready;
  logic                      ram_wen;
  logic [RAM_ADDR_WIDTH-1:0] ram_waddr;
  logic [31:0]               ram_wdata;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic [8:0]                words_written;

  modport master (
    input  in_valid, in_data,
    output in_ready, ram_wen, ram_waddr, ram_wdata,
    output busy, done, error, words_written
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, ram_wen, ram_waddr, ram_wdata,
    input  busy, done, error, words_written
  );
endinterface

// File: rtl/boot_image_loader.sv
// Framed byte-stream to RAM word loader: SYNC, LEN, 4*N data bytes, CSUM.
// All outputs are registered; busy doubles as the CPU reset hold.
//
// state  | meaning
// IDLE   | hunting for SYNC_BYTE, other bytes dropped
// LEN    | next byte is word count (0 means 256)
// DATA   | assembling LE words, one RAM write per 4 bytes
// CSUM   | next byte compared against running byte sum
// DONE   | image good, stream closed until reset
// ERR    | checksum bad, SYNC_BYTE restarts a frame
module boot_image_loader #(
  parameter int                        RAM_ADDR_WIDTH = 8,
  parameter logic [RAM_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [7:0]                SYNC_BYTE      = 8'hA5
) (
  input logic                 clk_i,
  input logic                 rst_i,
  boot_image_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e                    state_q;
  logic                      ready_q;
  logic                      wen_q;
  logic [RAM_ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]               wdata_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      error_q;
  logic [8:0]                words_q;
  logic [8:0]                n_words_q;
  logic [RAM_ADDR_WIDTH-1:0] ptr_q;
  logic [7:0]                acc_q;
  logic [1:0]                idx_q;
  logic [31:0]               asm_q;

  logic        accept;
  logic        last_word;
  logic [7:0]  acc_d;
  logic [31:0] asm_d;
  logic [8:0]  words_d;

  assign accept    = bus.in_valid && ready_q;
  assign acc_d     = acc_q + bus.in_data;
  assign words_d   = words_q + 9'd1;
  assign last_word = (words_d == n_words_q);

  always_comb begin
    asm_d = asm_q;
    asm_d[{idx_q, 3'b000} +: 8] = bus.in_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      wen_q     <= 1'b0;
      waddr_q   <= BASE_ADDR;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      words_q   <= '0;
      n_words_q <= '0;
      ptr_q     <= BASE_ADDR;
      acc_q     <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
    end else begin
      wen_q <= 1'b0;
      if (accept) begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.in_data == SYNC_BYTE) begin
              state_q <= S_LEN;
              busy_q  <= 1'b1;
            end
          end
          S_LEN: begin
            n_words_q <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            acc_q     <= '0;
            idx_q     <= '0;
            words_q   <= '0;
            ptr_q     <= BASE_ADDR;
            state_q   <= S_DATA;
          end
          S_DATA: begin
            acc_q <= acc_d;
            asm_q <= asm_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              wdata_q <= asm_d;
              waddr_q <= ptr_q;
              wen_q   <= 1'b1;
              ptr_q   <= ptr_q + 1'b1;
              words_q <= words_d;
              if (last_word) state_q <= S_CSUM;
            end
          end
          S_CSUM: begin
            busy_q <= 1'b0;
            if (bus.in_data == acc_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
          S_ERR: begin
            if (bus.in_data == SYNC_BYTE) begin
              state_q <= S_LEN;
              error_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready      = ready_q;
  assign bus.ram_wen       = wen_q;
  assign bus.ram_waddr     = waddr_q;
  assign bus.ram_wdata     = wdata_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.words_written = words_q;

  // A write strobe can only follow a 4th byte, so it is never two cycles wide.
  a_wen_single: assert property (@(posedge clk_i) disable iff (rst_i)
    wen_q |=> !wen_q);
  a_done_err_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(done_q && error_q));

endmodule
